gpio_event_ctrl: RTL and testbench

GPIO_EVENT_CTRL -- requirements
Module: gpio_event_ctrl

---
 rtl/gpio_event_pkg.sv | 9 +
 rtl/gpio_debounce.sv | 25 ++
 rtl/gpio_event_ctrl.sv | 114 +++++++++++
 tb/tb_gpio_event_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_event_pkg.sv
// gpio_event_pkg: command FSM states and gpio_config slice indices shared by the GPIO event block.
package gpio_event_pkg;
   typedef enum logic [2:0] {IDLE, POP, CAPTURE, EXEC, EMIT} state_t;
   localparam int DIR_SLICE       = 0;
   localparam int IRQ_EN_SLICE    = 1;
   localparam int EDGE_SEL_SLICE  = 2;
   localparam int BOTH_EDGE_SLICE = 3;
   localparam int NUM_SLICES      = 4;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-pin counter debouncer; dout follows din only after DEBOUNCE_CYCLES consecutive differing samples.
module gpio_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [CW-1:0] cnt;
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (din == dout) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         dout <= din;
         cnt  <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/gpio_event_ctrl.sv
// gpio_event_ctrl: FIFO-driven GPIO writer with pin sampling and sticky edge events.
// Define GPIO_EVENT_DEBOUNCE_EN to insert a gpio_debounce per pin after the synchroniser.
module gpio_event_ctrl
   import gpio_event_pkg::*;
#(
   parameter int DATAWIDTH         = 8,
   parameter int CONFIG_DATA_WIDTH = NUM_SLICES * DATAWIDTH,
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         empty,
   output logic                         read,
   input  logic [DATAWIDTH-1:0]         i_data,
   input  logic [CONFIG_DATA_WIDTH-1:0] gpio_config,
   output logic [DATAWIDTH-1:0]         gpio_oe,
   output logic [DATAWIDTH-1:0]         gpio_out,
   input  logic [DATAWIDTH-1:0]         gpio_in,
   input  logic                         rd_fifo_full,
   output logic                         rd_fifo_en,
   output logic [DATAWIDTH-1:0]         rd_gpio_out,
   output logic                         rd_is_event,
   output logic                         irq
);
   localparam int W = DATAWIDTH;
   logic [W-1:0] sync_q [SYNC_STAGES];
   logic [W-1:0] sin, deb, prev, pending, data, sample, ev, rise, fall;
   logic [W-1:0] dir, irq_en, edge_sel, both_edge;
   logic [CONFIG_DATA_WIDTH-1:0] cfg;
   logic [2:0] arm;
   logic armed, sample_wr, ev_wr;
   state_t state;

   assign sin = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

`ifdef GPIO_EVENT_DEBOUNCE_EN
   for (genvar i = 0; i < W; i++) begin : g_db
      gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clock(clock),
         .reset(reset),
         .din  (sin[i]),
         .dout (deb[i])
      );
   end
`else
   assign deb = sin;
`endif

   assign dir       = cfg[DIR_SLICE*W +: W];
   assign irq_en    = cfg[IRQ_EN_SLICE*W +: W];
   assign edge_sel  = cfg[EDGE_SEL_SLICE*W +: W];
   assign both_edge = cfg[BOTH_EDGE_SLICE*W +: W];
   assign gpio_oe   = dir;

   // Edges are held off until the synchroniser has flushed post-reset values
   assign armed = arm == 3'(SYNC_STAGES + 1);
   always_comb begin
      rise = deb & ~prev;
      fall = ~deb & prev;
      ev   = armed ? ((both_edge & (rise | fall)) | (~both_edge & ((edge_sel & rise) | (~edge_sel & fall)))) & irq_en & ~dir : '0;
   end

   assign sample_wr   = state == EMIT && !rd_fifo_full;
   assign ev_wr       = state != EMIT && |pending && !rd_fifo_full;
   assign rd_fifo_en  = sample_wr | ev_wr;
   assign rd_is_event = ev_wr;
   assign rd_gpio_out = sample_wr ? sample : ev_wr ? pending : '0;
   assign irq         = |pending;
   assign read        = state == POP;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cfg      <= '0;
         prev     <= '0;
         pending  <= '0;
         data     <= '0;
         sample   <= '0;
         gpio_out <= '0;
         arm      <= '0;
      end else begin
         cfg  <= gpio_config;
         prev <= deb;
         if (!armed) arm <= arm + 3'd1;
         // New edges are OR'd after the clear so nothing arriving during emission is lost
         pending <= ((ev_wr ? '0 : pending) | ev) & irq_en;
         case (state)
            IDLE:    if (!empty) state <= POP;
            POP:     state <= CAPTURE;
            CAPTURE: begin
               data  <= i_data;
               state <= EXEC;
            end
            EXEC:    begin
               gpio_out <= (gpio_out & ~dir) | (data & dir);
               sample   <= deb & ~dir;
               state    <= EMIT;
            end
            EMIT:    if (!rd_fifo_full) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gpio_event_ctrl.sv
// tb_gpio_event_ctrl: directed self-checking bench for gpio_event_ctrl.
module tb_gpio_event_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        empty = 1'b1;
   logic        read;
   logic [7:0]  i_data = '0;
   logic [31:0] gpio_config = '0;
   logic [7:0]  gpio_oe, gpio_out, gpio_in = '0, rd_gpio_out;
   logic        rd_fifo_full = 1'b0;
   logic        rd_fifo_en, rd_is_event, irq;
   int          total = 0;
   int          bad = 0;

   gpio_event_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .empty       (empty),
      .read        (read),
      .i_data      (i_data),
      .gpio_config (gpio_config),
      .gpio_oe     (gpio_oe),
      .gpio_out    (gpio_out),
      .gpio_in     (gpio_in),
      .rd_fifo_full(rd_fifo_full),
      .rd_fifo_en  (rd_fifo_en),
      .rd_gpio_out (rd_gpio_out),
      .rd_is_event (rd_is_event),
      .irq         (irq)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // gpio_config = {both_edge, edge_sel, irq_en, dir}
   function automatic logic [31:0] cfg(input logic [7:0] d, ie, es, be);
      return {be, es, ie, d};
   endfunction

   initial begin
      tick(3);
      check("rst_read", read, 0);
      check("rst_en", rd_fifo_en, 0);
      check("rst_irq", irq, 0);
      check("rst_out", gpio_out, 0);
      check("rst_oe", gpio_oe, 0);
      check("rst_rdata", rd_gpio_out, 0);
      check("rst_tag", rd_is_event, 0);
      reset = 1'b0;
      tick(5);

      // Command: dir=0x0F, data 0xA5, pins 0xA3
      gpio_config = cfg(8'h0F, 8'h00, 8'h00, 8'h00);
      gpio_in = 8'hA3;
      tick(4);
      check("cmd_oe", gpio_oe, 8'h0F);
      empty = 1'b0;
      tick();
      check("cmd_read_c1", read, 1);
      empty = 1'b1;
      i_data = 8'hA5;
      tick();
      check("cmd_read_c2", read, 0);
      tick();
      check("cmd_read_c3", read, 0);
      check("cmd_out_c3", gpio_out, 8'h00);
      check("cmd_en_c3", rd_fifo_en, 0);
      tick();
      check("cmd_out_c4", gpio_out, 8'h05);
      check("cmd_en_c4", rd_fifo_en, 1);
      check("cmd_tag_c4", rd_is_event, 0);
      check("cmd_sample", rd_gpio_out, 8'hA0);
      check("cmd_read_c4", read, 0);
      tick();
      check("cmd_en_c5", rd_fifo_en, 0);
      check("cmd_read_c5", read, 0);

      // Rising edge on pin 0
      gpio_in = 8'h00;
      tick(4);
      gpio_config = cfg(8'h00, 8'h01, 8'h01, 8'h00);
      tick(3);
      check("rise_idle_irq", irq, 0);
      gpio_in = 8'h01;
      tick(2);
      check("rise_early_irq", irq, 0);
      tick();
      check("rise_irq", irq, 1);
      check("rise_en", rd_fifo_en, 1);
      check("rise_tag", rd_is_event, 1);
      check("rise_mask", rd_gpio_out, 8'h01);
      tick();
      check("rise_irq_clr", irq, 0);
      check("rise_en_clr", rd_fifo_en, 0);

      // Both-edge pulse on pin 7 while read-back FIFO is full
      gpio_config = cfg(8'h00, 8'h80, 8'h00, 8'h80);
      rd_fifo_full = 1'b1;
      tick(2);
      gpio_in = 8'h81;
      tick(2);
      gpio_in = 8'h01;
      tick(5);
      check("full_irq", irq, 1);
      check("full_no_en", rd_fifo_en, 0);
      rd_fifo_full = 1'b0;
      #1;
      check("full_drop_en", rd_fifo_en, 1);
      check("full_drop_tag", rd_is_event, 1);
      check("full_drop_mask", rd_gpio_out, 8'h80);
      tick();
      check("full_single_en", rd_fifo_en, 0);
      check("full_irq_clr", irq, 0);

      // Sample in EMIT competes with a pending event
      rd_fifo_full = 1'b1;
      gpio_config = cfg(8'h0F, 8'h10, 8'h10, 8'h00);
      gpio_in = 8'h11;
      tick(4);
      check("prio_irq", irq, 1);
      empty = 1'b0;
      i_data = 8'h3C;
      tick();
      empty = 1'b1;
      tick(5);
      check("prio_wait_en", rd_fifo_en, 0);
      check("prio_out", gpio_out, 8'h0C);
      rd_fifo_full = 1'b0;
      #1;
      check("prio_s_en", rd_fifo_en, 1);
      check("prio_s_tag", rd_is_event, 0);
      check("prio_s_data", rd_gpio_out, 8'h10);
      tick();
      check("prio_e_en", rd_fifo_en, 1);
      check("prio_e_tag", rd_is_event, 1);
      check("prio_e_data", rd_gpio_out, 8'h10);
      tick();
      check("prio_done_en", rd_fifo_en, 0);
      check("prio_done_irq", irq, 0);

      // Reset while in CAPTURE abandons the command
      gpio_config = cfg(8'hFF, 8'h00, 8'h00, 8'h00);
      tick(2);
      empty = 1'b0;
      i_data = 8'hFF;
      tick();
      empty = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_out", gpio_out, 0);
      check("abort_oe", gpio_oe, 0);
      for (int i = 0; i < 4; i++) begin
         check("abort_en", rd_fifo_en, 0);
         check("abort_read", read, 0);
         tick();
      end
      check("abort_out_late", gpio_out, 0);
      check("abort_oe_late", gpio_oe, 8'hFF);

`ifdef GPIO_EVENT_DEBOUNCE_EN
      begin
         int writes;
         gpio_in = 8'h00;
         reset = 1'b1;
         tick(2);
         reset = 1'b0;
         gpio_config = cfg(8'h00, 8'h02, 8'h02, 8'h00);
         tick(25);
         gpio_in = 8'h02;
         tick(3);
         gpio_in = 8'h00;
         writes = 0;
         for (int i = 0; i < 30; i++) begin
            tick();
            writes += int'(rd_fifo_en);
         end
         check("db_glitch_writes", writes, 0);
         check("db_glitch_irq", irq, 0);
         gpio_in = 8'h02;
         writes = 0;
         for (int i = 0; i < 40; i++) begin
            tick();
            writes += int'(rd_fifo_en);
         end
         check("db_level_writes", writes, 1);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
